usb_tx_encoder: RTL

//  Downstream neighbour of the protocol stage. Accepts one 99-bit left-aligned packet vector
//  (pkt_in / pkt_in_avail) and serialises it: SYNC, PID, payload, serially computed CRC5/CRC16,
//  bit stuffing, NRZI, EOP. Drives the full-speed D+/D- pair. Pulses pkt_sent when the packet is done.

---
 rtl/usb_tx_encoder_if.sv | 12 +
 rtl/usb_tx_encoder.sv | 105 ++++++++++
 2 files changed

// File: rtl/usb_tx_encoder_if.sv
// usb_tx_encoder_if: packet handshake and full-speed line signals between protocol stage and encoder
interface usb_tx_encoder_if;
  logic [98:0] pkt_in;
  logic pkt_in_avail;
  logic pkt_sent;
  logic busy;
  logic dp_out;
  logic dm_out;
  logic bus_en;
  modport master(output pkt_in, pkt_in_avail, input pkt_sent, busy, dp_out, dm_out, bus_en);
  modport slave(input pkt_in, pkt_in_avail, output pkt_sent, busy, dp_out, dm_out, bus_en);
endinterface

// File: rtl/usb_tx_encoder.sv
// usb_tx_encoder: USB FS packet serialiser (SYNC/PID/payload/CRC, NRZI, EOP); ENC_STUFF_EN enables bit stuffing
module usb_tx_encoder #(
  parameter int EOP_SE0_LEN = 2,
  parameter int STUFF_RUN = 6
) (
  input logic clk,
  input logic rst,
  usb_tx_encoder_if.slave tx
);
  typedef enum logic [2:0] {IDLE, SHIFT, EOP, DONE, REARM} state_t;
  localparam logic [6:0] SE0_N = 7'(EOP_SE0_LEN);
  state_t state_q, state_d;
  logic [98:0] sr_q, sr_d;
  logic [6:0] cnt_q, cnt_d, len_q, len_d, pay_end;
  logic [15:0] crc_q, crc_d;
  logic [1:0] cls;
  logic tok_q, tok_d, lvl_q, lvl_d;
  logic stuff, stuff_next, crc_msb, raw_bit, wire_bit, in_pay, in_crc, last_raw, se0, line;
  assign cls = {tx.pkt_in[89], tx.pkt_in[90]};
  assign pay_end = tok_q ? 7'd27 : 7'd80;
  assign in_pay = cnt_q >= 7'd16 && cnt_q < pay_end;
  assign in_crc = cnt_q >= pay_end;
  assign crc_msb = tok_q ? crc_q[4] : crc_q[15];
  assign raw_bit = in_crc ? ~crc_msb : sr_q[98];
  assign wire_bit = !stuff && raw_bit;
  assign last_raw = cnt_q == len_q - 7'd1;
`ifdef ENC_STUFF_EN
  localparam int SW = $clog2(STUFF_RUN + 1);
  logic [SW-1:0] ones_q, ones_d;
  assign stuff = ones_q == SW'(STUFF_RUN);
  assign ones_d = state_q != SHIFT ? '0 : (wire_bit ? ones_q + 1'b1 : '0);
  assign stuff_next = ones_d == SW'(STUFF_RUN);
  always_ff @(posedge clk) ones_q <= rst ? '0 : ones_d;
`else
  logic unused_stuff_run;
  assign unused_stuff_run = STUFF_RUN != 0;
  assign stuff = 1'b0;
  assign stuff_next = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      lvl_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
    sr_q <= sr_d;
    len_q <= len_d;
    tok_q <= tok_d;
    crc_q <= crc_d;
  end
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    len_d = len_q;
    tok_d = tok_q;
    crc_d = crc_q;
    lvl_d = lvl_q;
    case (state_q)
      IDLE: if (tx.pkt_in_avail) begin
        state_d = SHIFT;
        sr_d = tx.pkt_in;
        cnt_d = '0;
        tok_d = cls == 2'b01;
        len_d = cls == 2'b01 ? 7'd32 : cls == 2'b11 ? 7'd96 : 7'd16;
        crc_d = '1;
        lvl_d = 1'b1;
      end
      SHIFT: begin
        lvl_d = wire_bit ? lvl_q : ~lvl_q;
        if (!stuff) begin
          sr_d = sr_q << 1;
          cnt_d = cnt_q + 7'd1;
          crc_d = in_pay ? {crc_q[14:0], 1'b0} ^ ((raw_bit ^ crc_msb) ? (tok_q ? 16'h0005 : 16'h8005) : 16'h0000)
                : in_crc ? crc_q << 1 : crc_q;
        end
        // a stuffed bit owed after the final raw bit still goes out before EOP
        if (stuff ? cnt_q == len_q : last_raw && !stuff_next) begin
          state_d = EOP;
          cnt_d = '0;
        end
      end
      EOP: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == SE0_N) state_d = DONE;
      end
      DONE: state_d = REARM;
      REARM: if (!tx.pkt_in_avail) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    se0 = state_q == EOP && cnt_q < SE0_N;
    line = state_q == SHIFT ? (wire_bit ? lvl_q : ~lvl_q) : 1'b1;
    tx.busy = state_q != IDLE;
    tx.pkt_sent = state_q == DONE;
    tx.bus_en = state_q == SHIFT || state_q == EOP;
    tx.dp_out = !se0 && line;
    tx.dm_out = !se0 && !line;
  end
endmodule
